noc_packetizer: RTL

- Local-port network interface that sits directly upstream of the router's local input channel.
- Accepts a transfer command (destination X/Y, payload length) plus an AXI-Stream payload from a core.
- Emits one header flit, which the router arbiter decodes into target_x/target_y, followed by the payload flits, with tlast placed by the block.
- Output is a single registered stage.

---
 rtl/noc_pkg.sv | 48 ++++
 rtl/noc_packetizer_if.sv | 11 +
 rtl/axis_out_reg.sv | 32 +++
 rtl/noc_packetizer.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/noc_pkg.sv
// rtl/noc_pkg.sv - shared NoC stream types, header layout and FSM encoding
package noc_pkg;

    localparam int AXIS_TDATA_W = 32;

    // Header field offsets for the default 4x4 mesh (2-bit coordinates)
    localparam int NOC_X_W   = 2;
    localparam int NOC_Y_W   = 2;
    localparam int DST_X_LSB = 0;
    localparam int DST_Y_LSB = NOC_X_W;
    localparam int SRC_X_LSB = NOC_X_W + NOC_Y_W;
    localparam int SRC_Y_LSB = 2 * NOC_X_W + NOC_Y_W;
    localparam int LEN_LSB   = 2 * NOC_X_W + 2 * NOC_Y_W;

    typedef struct packed {
        logic [AXIS_TDATA_W-1:0] tdata;
        logic                    tvalid;
        logic                    tlast;
    } axis_mosi_t;

    typedef struct packed {
        logic tready;
    } axis_miso_t;

    typedef enum logic [1:0] {
        IDLE,
        HEADER,
        PAYLOAD
    } pkt_state_e;

    // Fields must arrive zero-extended; xw/yw give the coordinate widths of the mesh
    function automatic logic [AXIS_TDATA_W-1:0] pack_header(
        input int                      xw,
        input int                      yw,
        input logic [AXIS_TDATA_W-1:0] dst_x,
        input logic [AXIS_TDATA_W-1:0] dst_y,
        input logic [AXIS_TDATA_W-1:0] src_x,
        input logic [AXIS_TDATA_W-1:0] src_y,
        input logic [AXIS_TDATA_W-1:0] len
    );
        return dst_x
             | (dst_y << xw)
             | (src_x << (xw + yw))
             | (src_y << (2 * xw + yw))
             | (len   << (2 * (xw + yw)));
    endfunction

endpackage

// File: rtl/noc_packetizer_if.sv
// rtl/noc_packetizer_if.sv - flit stream bundle between packetizer and router local port
interface noc_packetizer_if;
    import noc_pkg::*;

    axis_mosi_t mosi;
    axis_miso_t miso;

    modport master (output mosi, input miso);
    modport slave  (input mosi, output miso);

endinterface

// File: rtl/axis_out_reg.sv
// rtl/axis_out_reg.sv - single-entry registered stream slice driving the flit bus
module axis_out_reg
    import noc_pkg::*;
(
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_load,
    input  logic [AXIS_TDATA_W-1:0] i_tdata,
    input  logic                    i_tlast,
    output logic                    o_slot,
    noc_packetizer_if.master        m
);

    axis_mosi_t r_out;

    assign o_slot = !r_out.tvalid || m.miso.tready;
    assign m.mosi = r_out;

    // Data and tlast only move on a load, so they stay put while stalled
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_out <= '0;
        end else if (o_slot) begin
            r_out.tvalid <= i_load;
            if (i_load) begin
                r_out.tdata <= i_tdata;
                r_out.tlast <= i_tlast;
            end
        end
    end

endmodule

// File: rtl/noc_packetizer.sv
// rtl/noc_packetizer.sv - turns a command plus payload stream into header + payload flits
module noc_packetizer
    import noc_pkg::*;
#(
    parameter int AXIS_DATA_WIDTH     = AXIS_TDATA_W,
    parameter int MAX_ROUTERS_X       = 4,
    parameter int MAX_ROUTERS_X_WIDTH = $clog2(MAX_ROUTERS_X),
    parameter int MAX_ROUTERS_Y       = 4,
    parameter int MAX_ROUTERS_Y_WIDTH = $clog2(MAX_ROUTERS_Y),
    parameter int ROUTER_X            = 0,
    parameter int ROUTER_Y            = 0,
    parameter int LEN_WIDTH           = 8
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           cmd_valid_i,
    output logic                           cmd_ready_o,
    input  logic [MAX_ROUTERS_X_WIDTH-1:0] cmd_x_i,
    input  logic [MAX_ROUTERS_Y_WIDTH-1:0] cmd_y_i,
    input  logic [LEN_WIDTH-1:0]           cmd_len_i,
    input  axis_mosi_t                     in_mosi_i,
    output axis_miso_t                     in_miso_o,
    output axis_mosi_t                     out_mosi_o,
    input  axis_miso_t                     out_miso_i,
    output logic                           err_o
);

    localparam logic [MAX_ROUTERS_X_WIDTH-1:0] SRC_X = MAX_ROUTERS_X_WIDTH'(ROUTER_X);
    localparam logic [MAX_ROUTERS_Y_WIDTH-1:0] SRC_Y = MAX_ROUTERS_Y_WIDTH'(ROUTER_Y);

    pkt_state_e                     r_state;
    logic                           r_cmd_ready;
    logic                           r_err;
    logic [MAX_ROUTERS_X_WIDTH-1:0] r_dst_x;
    logic [MAX_ROUTERS_Y_WIDTH-1:0] r_dst_y;
    logic [LEN_WIDTH-1:0]           r_len;
    logic [LEN_WIDTH-1:0]           r_cnt;

    logic                       w_slot;
    logic                       w_load;
    logic                       w_tlast;
    logic                       w_in_hs;
    logic                       w_is_last;
    logic [AXIS_DATA_WIDTH-1:0] w_tdata;
    logic [AXIS_DATA_WIDTH-1:0] w_header;

    noc_packetizer_if u_out_if ();

    assign u_out_if.miso = out_miso_i;
    assign out_mosi_o    = u_out_if.mosi;

    axis_out_reg u_out_reg (
        .i_clk   (clk_i),
        .i_rst   (rst_i),
        .i_load  (w_load),
        .i_tdata (w_tdata),
        .i_tlast (w_tlast),
        .o_slot  (w_slot),
        .m       (u_out_if.master)
    );

    assign w_header = pack_header(MAX_ROUTERS_X_WIDTH, MAX_ROUTERS_Y_WIDTH,
                                  AXIS_DATA_WIDTH'(r_dst_x), AXIS_DATA_WIDTH'(r_dst_y),
                                  AXIS_DATA_WIDTH'(SRC_X), AXIS_DATA_WIDTH'(SRC_Y),
                                  AXIS_DATA_WIDTH'(r_len));

    // Only evaluated in PAYLOAD, where r_len is never zero
    assign w_is_last = (r_cnt == r_len - LEN_WIDTH'(1));
    assign w_in_hs   = (r_state == PAYLOAD) && w_slot && in_mosi_i.tvalid;

    assign in_miso_o.tready = (r_state == PAYLOAD) && w_slot;
    assign cmd_ready_o      = r_cmd_ready;
    assign err_o            = r_err;

    always_comb begin
        w_load  = 1'b0;
        w_tdata = w_header;
        w_tlast = (r_len == '0);
        case (r_state)
            HEADER:  w_load = w_slot;
            PAYLOAD: begin
                w_load  = w_in_hs;
                w_tdata = in_mosi_i.tdata;
                w_tlast = w_is_last;
            end
            default: w_load = 1'b0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= IDLE;
            r_cmd_ready <= 1'b1;
            r_err       <= 1'b0;
            r_dst_x     <= '0;
            r_dst_y     <= '0;
            r_len       <= '0;
            r_cnt       <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (cmd_valid_i && r_cmd_ready) begin
                        r_dst_x     <= cmd_x_i;
                        r_dst_y     <= cmd_y_i;
                        r_len       <= cmd_len_i;
                        r_cnt       <= '0;
                        r_cmd_ready <= 1'b0;
                        r_state     <= HEADER;
                    end
                end
                HEADER: begin
                    if (w_slot) begin
                        if (r_len != '0) begin
                            r_state <= PAYLOAD;
                        end else begin
                            r_state     <= IDLE;
                            r_cmd_ready <= 1'b1;
                        end
                    end
                end
                PAYLOAD: begin
                    if (w_in_hs) begin
                        r_cnt <= r_cnt + LEN_WIDTH'(1);
                        if (in_mosi_i.tlast != w_is_last) begin
                            r_err <= 1'b1;
                        end
                        if (w_is_last) begin
                            r_state     <= IDLE;
                            r_cmd_ready <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_cmd_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule
